// File: rtl/mcu32x_trace_pkg.sv
// Shared definitions for the MCU32X data-bus tracer.
// Contents:
//   trace_state_t : tracer state encoding, also driven on the state port
//   trig_mode_t   : trigger mode encoding applied to the trig_mode input
//   entry_width / *_lsb : layout of one buffer entry
//                         {ts, mem_read, mem_write, address, result}
package mcu32x_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    typedef enum logic [1:0] {
        TRIG_IMM   = 2'd0,
        TRIG_ANY   = 2'd1,
        TRIG_WRITE = 2'd2,
        TRIG_READ  = 2'd3
    } trig_mode_t;

    function automatic int entry_width(input int ts_w, input int addr_w, input int data_w);
        return ts_w + 2 + addr_w + data_w;
    endfunction

    function automatic int result_lsb();
        return 0;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int wr_bit(input int addr_w, input int data_w);
        return data_w + addr_w;
    endfunction

    function automatic int rd_bit(input int addr_w, input int data_w);
        return data_w + addr_w + 1;
    endfunction

    function automatic int ts_lsb(input int addr_w, input int data_w);
        return data_w + addr_w + 2;
    endfunction

endpackage

// File: rtl/mcu32x_trace_ram.sv
// Trace storage: DEPTH x WIDTH, one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk   : system clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from storage
module mcu32x_trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 82
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mcu32x_bus_tracer.sv
// Passive trace buffer for the MCU32X data-side bus. Samples result,
// address and strobes into a circular buffer, stops a programmable number
// of events after an address trigger, then drains oldest-first over a
// valid/ready port.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   result, address       : sampled core buses
//   mem_read, mem_write   : sampled strobes
//   arm, disarm           : control pulses (disarm wins)
//   trig_mode/addr/mask   : trigger configuration
//   post_count            : events recorded after the trigger event
//   rd_valid/ready/data   : readout port, live only in DONE
//   state, count, overflow, done : status
//
// state | meaning
// IDLE  | not capturing, buffer frozen
// ARMED | recording every event, watching for the trigger
// POST  | trigger seen, recording post_left more events
// DONE  | capture frozen, draining through the readout port
module mcu32x_bus_tracer
    import mcu32x_trace_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 16,
    parameter int TS_W        = 16,
    parameter int CAPTURE_ALL = 0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [DATA_W-1:0]                result,
    input  logic [ADDR_W-1:0]                address,
    input  logic                             mem_read,
    input  logic                             mem_write,
    input  logic                             arm,
    input  logic                             disarm,
    input  logic [1:0]                       trig_mode,
    input  logic [ADDR_W-1:0]                trig_addr,
    input  logic [ADDR_W-1:0]                trig_mask,
    input  logic [$clog2(DEPTH)-1:0]         post_count,
    output logic                             rd_valid,
    input  logic                             rd_ready,
    output logic [TS_W+2+ADDR_W+DATA_W-1:0]  rd_data,
    output logic [1:0]                       state,
    output logic [$clog2(DEPTH):0]           count,
    output logic                             overflow,
    output logic                             done
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = entry_width(TS_W, ADDR_W, DATA_W);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    trace_state_t     state_q, state_d;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, post_left;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic [TS_W-1:0]  ts_q;

    logic evt, match, trig_hit;
    logic we, clr, pop, load_post, dec_post;
    logic [ENTRY_W-1:0] wdata;

    assign evt   = (CAPTURE_ALL != 0) | mem_read | mem_write;
    assign match = ((address ^ trig_addr) & trig_mask) == '0;

    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode_t'(trig_mode))
            TRIG_IMM:   trig_hit = 1'b1;
            TRIG_ANY:   trig_hit = match;
            TRIG_WRITE: trig_hit = match & mem_write;
            TRIG_READ:  trig_hit = match & mem_read;
            default:    trig_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        we        = 1'b0;
        clr       = 1'b0;
        pop       = 1'b0;
        load_post = 1'b0;
        dec_post  = 1'b0;
        if (disarm) begin
            state_d = ST_IDLE;
        end else if (arm) begin
            state_d = ST_ARMED;
            clr     = 1'b1;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (evt) begin
                        we = 1'b1;
                        if (trig_hit) begin
                            load_post = 1'b1;
                            state_d   = (post_count == '0) ? ST_DONE : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (evt) begin
                        we       = 1'b1;
                        dec_post = 1'b1;
                        // POST is only entered with post_left >= 1
                        if (post_left == PTR_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: pop = rd_valid & rd_ready;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            post_left  <= '0;
            ts_q       <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_q + 1'b1;
            if (clr) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else if (we) begin
                wr_ptr <= wr_ptr + 1'b1;
                // Full buffer: drop the oldest entry to make room
                if (count_q == FULL) begin
                    rd_ptr     <= rd_ptr + 1'b1;
                    overflow_q <= 1'b1;
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end else if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                count_q <= count_q - 1'b1;
            end
            if (load_post) begin
                post_left <= post_count;
            end else if (dec_post) begin
                post_left <= post_left - 1'b1;
            end
        end
    end

    assign wdata = {ts_q, mem_read, mem_write, address, result};

    mcu32x_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (we & reset_n),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign rd_valid = (state_q == ST_DONE) && (count_q != '0);
    assign state    = state_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_mcu32x_bus_tracer.sv
module tb_mcu32x_bus_tracer;

    localparam int DW = 32, AW = 32, DEPTH = 16, TSW = 16;
    localparam int EW = TSW + 2 + AW + DW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] result = '0;
    logic [AW-1:0] address = '0;
    logic          mem_read = 1'b0, mem_write = 1'b0;
    logic          arm = 1'b0, disarm = 1'b0;
    logic [1:0]    trig_mode = 2'd0;
    logic [AW-1:0] trig_addr = '0, trig_mask = '0;
    logic [3:0]    post_count = '0;
    logic          rd_valid, rd_ready = 1'b0;
    logic [EW-1:0] rd_data;
    logic [1:0]    state;
    logic [4:0]    count;
    logic          overflow, done;

    mcu32x_bus_tracer #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .TS_W(TSW), .CAPTURE_ALL(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .result(result), .address(address),
        .mem_read(mem_read), .mem_write(mem_write), .arm(arm), .disarm(disarm),
        .trig_mode(trig_mode), .trig_addr(trig_addr), .trig_mask(trig_mask),
        .post_count(post_count), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .state(state), .count(count), .overflow(overflow),
        .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the buffer is a queue of recorded entries
    logic [EW-1:0] q[$];
    int m_st = 0;      // 0 idle, 1 armed, 2 post, 3 done
    int m_post = 0;
    bit m_ovf = 1'b0;
    int m_ts = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_record();
        q.push_back({16'(m_ts), mem_read, mem_write, address, result});
        if (q.size() > DEPTH) begin
            void'(q.pop_front());
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_step();
        bit ev, mt, hit;
        if (!reset_n) begin
            m_st = 0; q.delete(); m_ovf = 1'b0; m_ts = 0; m_post = 0;
            return;
        end
        ev  = mem_read | mem_write;
        mt  = ((address ^ trig_addr) & trig_mask) == 0;
        hit = (trig_mode == 0) || (trig_mode == 1 && mt) ||
              (trig_mode == 2 && mt && mem_write) || (trig_mode == 3 && mt && mem_read);
        if (disarm) m_st = 0;
        else if (arm) begin
            m_st = 1; q.delete(); m_ovf = 1'b0;
        end else if (m_st == 1 && ev) begin
            model_record();
            if (hit) begin
                m_post = int'(post_count);
                m_st = (m_post == 0) ? 3 : 2;
            end
        end else if (m_st == 2 && ev) begin
            model_record();
            m_post--;
            if (m_post == 0) m_st = 3;
        end else if (m_st == 3 && rd_ready && q.size() > 0) begin
            void'(q.pop_front());
        end
        m_ts = (m_ts + 1) % 65536;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("state", 128'(state), 128'(m_st));
        chk("count", 128'(count), 128'(q.size()));
        chk("overflow", 128'(overflow), 128'(m_ovf));
        chk("done", 128'(done), 128'(m_st == 3));
        chk("rd_valid", 128'(rd_valid), 128'(m_st == 3 && q.size() > 0));
        if (m_st == 3 && q.size() > 0) chk("rd_data", 128'(rd_data), 128'(q[0]));
    endtask

    task automatic bus(input bit rd, input bit wr, input logic [31:0] a);
        mem_read = rd; mem_write = wr; address = a; result = $urandom;
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    logic [EW-1:0] held;
    int prev_ts;
    int xfers;

    initial begin
        // reset, then reset again in the middle of a capture
        tick(); tick();
        reset_n = 1'b1;
        trig_mode = 2'd1; trig_addr = 32'hFFFF_0000; trig_mask = '1;
        pulse_arm();
        for (int i = 0; i < 3; i++) bus(1'b0, 1'b1, 32'h40 + 32'(4 * i));
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        chk("rst_state", 128'(state), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_valid", 128'(rd_valid), 128'(0));
        chk("rst_ovf", 128'(overflow), 128'(0));

        // immediate trigger, post_count 3
        trig_mode = 2'd0; post_count = 4'd3;
        pulse_arm();
        for (int i = 0; i < 6; i++) bus(1'b0, 1'b1, 32'h100 + 32'(4 * i));
        chk("imm_done", 128'(done), 128'(1));
        chk("imm_count", 128'(count), 128'(4));
        rd_ready = 1'b1;
        prev_ts = -1;
        for (int i = 0; i < 4; i++) begin
            chk("imm_addr", 128'(rd_data[63:32]), 128'(32'h100 + 32'(4 * i)));
            chk("imm_ts_incr", 128'(int'(rd_data[81:66]) > prev_ts), 128'(1));
            prev_ts = int'(rd_data[81:66]);
            tick();
        end
        rd_ready = 1'b0;
        chk("imm_empty", 128'(rd_valid), 128'(0));

        // write trigger with overflow
        trig_mode = 2'd2; trig_addr = 32'h2000; trig_mask = 32'hFFFF_FFF0; post_count = 4'd2;
        pulse_arm();
        for (int i = 0; i < 20; i++) bus(1'b1, 1'b0, 32'h3000 + 32'($urandom_range(0, 63) * 4));
        bus(1'b0, 1'b1, 32'h2008);
        bus(1'b1, 1'b0, 32'h2004);
        bus(1'b1, 1'b0, 32'h2000);
        chk("wt_count", 128'(count), 128'(16));
        chk("wt_ovf", 128'(overflow), 128'(1));
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 13) begin
                chk("wt_trig_addr", 128'(rd_data[63:32]), 128'(32'h2008));
                chk("wt_trig_wr", 128'(rd_data[64]), 128'(1));
            end
            tick();
        end
        rd_ready = 1'b0;

        // read trigger ignores a matching write; no strobes means no writes
        trig_mode = 2'd3;
        pulse_arm();
        bus(1'b0, 1'b1, 32'h2000);
        chk("rdtrig_armed", 128'(state), 128'(1));
        trig_mode = 2'd0;
        pulse_arm();
        for (int i = 0; i < 4; i++) tick();
        chk("nostrobe_count", 128'(count), 128'(0));
        chk("nostrobe_state", 128'(state), 128'(1));

        // backpressure
        post_count = 4'd3;
        pulse_arm();
        for (int i = 0; i < 4; i++) bus(1'b1, 1'b0, 32'h500 + 32'(i));
        chk("bp_count", 128'(count), 128'(4));
        xfers = 0;
        for (int i = 0; i < 6; i++) begin
            rd_ready = (i == 0 || i >= 3);
            held = rd_data;
            if (rd_ready && rd_valid) xfers++;
            tick();
            if (!rd_ready) chk("bp_stable", 128'(rd_data), 128'(held));
        end
        rd_ready = 1'b0;
        chk("bp_xfers", 128'(xfers), 128'(4));
        chk("bp_valid_low", 128'(rd_valid), 128'(0));

        // arm/disarm priority, re-arm from DONE
        pulse_arm();
        arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
        chk("prio_idle", 128'(state), 128'(0));
        post_count = 4'd4;
        pulse_arm();
        for (int i = 0; i < 5; i++) bus(1'b0, 1'b1, 32'h600 + 32'(i));
        chk("rearm_pre_count", 128'(count), 128'(5));
        pulse_arm();
        chk("rearm_state", 128'(state), 128'(1));
        chk("rearm_count", 128'(count), 128'(0));

        // randomized traffic against the model
        trig_addr = 32'h2000;
        for (int i = 0; i < 600; i++) begin
            arm = ($urandom_range(0, 39) == 0);
            disarm = ($urandom_range(0, 119) == 0);
            trig_mode = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: trig_mask = '0;
                1: trig_mask = 32'hFFFF_FFF0;
                default: trig_mask = '1;
            endcase
            if ($urandom_range(0, 9) == 0) post_count = 4'($urandom_range(0, 15));
            mem_read = $urandom_range(0, 2) == 0;
            mem_write = $urandom_range(0, 2) == 0;
            address = ($urandom_range(0, 1) == 0) ? 32'h2000 + 32'($urandom_range(0, 7) * 4) : $urandom;
            result = $urandom;
            rd_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        arm = 1'b0; disarm = 1'b0; mem_read = 1'b0; mem_write = 1'b0; rd_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
